adc_cfg_sequencer: RTL
======================

Name: adc_cfg_sequencer

Overview:
Parametrised control-register programming engine for the serial-port ADC front end. It replaces the fixed CRA..CRH loader with a sequencer that runs from a start/done handshake. NUM_REGS register bytes are latched from a packed bus and shifted out as 16-bit control words on SDI/SDIFS. An optional readback pass re-reads every register over SDO/SDOFS and flags mismatches. The block sits between the host configuration logic and the ADC serial port. All logic runs on the system clock; SCLK is sampled, not used as a clock.

Parameters:
NUM_REGS, 8, number of control registers programmed (1..8); register address = index 0..NUM_REGS-1.
DEV_ADDR, 3'b000, device address field, word bits 13:11.
GAP_SCLKS, 2, idle SCLK periods between consecutive frames (>=1).
TIMEOUT_SCLKS, 64, SCLK rising edges to wait for SDOFS after a read request.

Ports:
clk  in  1  system clock; must be >= 4x the SCLK frequency.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request; accepted only when busy=0.
verify  in  1  sampled with start; 1 = run the readback pass after the writes.
cfg_data  in  8*NUM_REGS  register bytes; byte i = cfg_data[8i+7:8i]; latched on an accepted start.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when the sequence ends.
err  out  1  sticky; set on any mismatch or timeout; cleared on an accepted start.
mismatch  out  NUM_REGS  bit i set if register i failed readback; cleared on an accepted start.
SCLK  in  1  serial clock driven by the ADC.
SDOFS  in  1  ADC output frame sync.
SDO  in  1  ADC serial data out.
SDIFS  out  1  frame sync to the ADC; high for the first bit period of each frame.
SDI  out  1  serial data to the ADC, MSB first.
SE  out  1  serial enable; equals busy.

Behaviour:
- Reset values: SDI=0, SDIFS=0, SE=0, busy=0, done=0, err=0, mismatch=0, FSM=IDLE, index=0.
- Reset asserted mid-sequence aborts immediately; no partial frame is resumed.
- Synchronisation: SCLK, SDOFS and SDO pass through 2-flop synchronisers. sclk_rise and sclk_fall are one-clk pulses derived from the synchronised SCLK.
- Outputs update only on sclk_rise, so the ADC samples on the SCLK falling edge.
- Write word: {1'b1, 1'b0, DEV_ADDR, idx[2:0], byte[idx]}.
- Read word: {1'b1, 1'b1, DEV_ADDR, idx[2:0], 8'h00}.
- FSM states: IDLE, LOAD, SHIFT, GAP, RD_WAIT, RD_CAP, FINISH.
- IDLE: on start, latch cfg_data and verify, set idx=0, clear err and mismatch, go to LOAD. A start received while busy is ignored.
- LOAD: build the word for idx. On the next sclk_rise drive SDIFS=1 and SDI=word[15], set bit count to 15, go to SHIFT.
- SHIFT: each sclk_rise drives SDIFS=0 and the next bit, MSB first. After bit0 has been driven for one full period, the next sclk_rise drives SDI=0 and enters GAP.
- Frame timing: exactly 16 SCLK periods per frame; SDIFS is high for exactly 1 period.
- GAP: count GAP_SCLKS sclk_rise events, then:
  - write pass, idx < NUM_REGS-1: idx+1, go to LOAD.
  - write pass, last idx, verify=1: idx=0, enter the read pass at LOAD (read word).
  - write pass, last idx, verify=0: go to FINISH.
  - read pass: go to RD_WAIT.
- RD_WAIT: on the first sclk_fall where SDOFS=1, capture SDO as bit15 and go to RD_CAP. If TIMEOUT_SCLKS sclk_rise events pass first, set mismatch[idx] and err, then advance.
- RD_CAP: capture 15 more SDO bits on sclk_fall. Compare captured[10:8]==idx and captured[7:0]==byte[idx]. On inequality set mismatch[idx] and err. Advance idx or go to FINISH after the last register.
- FINISH: pulse done for one clk, clear busy, return to IDLE. SE falls in the same cycle as busy.
- SDOFS frames arriving outside RD_WAIT are ignored.
- Total write-only duration: NUM_REGS*(16+GAP_SCLKS) SCLK periods, plus up to 1 SCLK period of initial alignment and 3 clk of synchroniser latency.

Test Plan:
- NUM_REGS=8, DEV_ADDR=0, verify=0, bytes 0x81,0x12,0x01,0,0,0,0,0 -> 8 frames decoded as 0x8081, 0x8112, 0x8201, 0x8300..0x8700. SDIFS is 1 SCLK wide per frame, 2 idle SCLKs between frames, done pulses once, err=0.
- verify=1 with an ADC model echoing the bytes -> 8 write frames, then 8 read words 0xC000|idx<<8. mismatch=0, err=0, done once.
- verify=1, model returns 0x55 for register 3 instead of 0x00 -> mismatch=8'h08, err=1. err persists after done and clears on the next start.
- verify=1, model never asserts SDOFS -> each register times out after 64 SCLK rises. mismatch=8'hFF, err=1, done pulses.
- start pulsed again mid-sequence -> ignored, frame count unchanged. rst asserted during bit 7 of frame 2 -> SDI=SDIFS=SE=busy=0 immediately, and a fresh start restarts at idx=0.
- NUM_REGS=1, GAP_SCLKS=1 -> single frame 0x80xx, done after 17 SCLK periods plus sync latency.

Source files
------------

// File: rtl/adc_cfg_sequencer.sv
// Control-register programming engine for the ADC serial port: shifts NUM_REGS
// 16-bit write words out on SDI/SDIFS, then optionally reads each one back over SDO/SDOFS.
module adc_cfg_sequencer #(
  parameter int         NUM_REGS      = 8,
  parameter logic [2:0] DEV_ADDR      = 3'b000,
  parameter int         GAP_SCLKS     = 2,
  parameter int         TIMEOUT_SCLKS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  verify,
  input  logic [8*NUM_REGS-1:0] cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_REGS-1:0]   mismatch,
  input  logic                  SCLK,
  input  logic                  SDOFS,
  input  logic                  SDO,
  output logic                  SDIFS,
  output logic                  SDI,
  output logic                  SE
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_GAP     = 3'd3;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;
  localparam logic [2:0] ST_RD_CAP  = 3'd5;
  localparam logic [2:0] ST_FINISH  = 3'd6;

  localparam int GW = $clog2(GAP_SCLKS + 1);
  localparam int TW = $clog2(TIMEOUT_SCLKS + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SCLKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_SCLKS - 1);

  logic [2:0]            state_reg;
  logic [2:0]            idx_reg;
  logic [8*NUM_REGS-1:0] bytes_reg;
  logic                  verify_reg;
  logic                  rd_pass_reg;
  logic [14:0]           word_reg;
  logic [3:0]            bit_cnt_reg;
  logic [GW-1:0]         gap_cnt_reg;
  logic [TW-1:0]         to_cnt_reg;
  logic [9:0]            cap_reg;
  logic [3:0]            cap_cnt_reg;

  logic [1:0] sclk_sync_reg;
  logic [1:0] sdofs_sync_reg;
  logic [1:0] sdo_sync_reg;
  logic       sclk_prev_reg;

  logic                sclk_s, sdofs_s, sdo_s;
  logic                sclk_rise, sclk_fall;
  logic [7:0]          byte_arr [8];
  logic [NUM_REGS-1:0] idx_onehot;
  logic [7:0]          cur_byte;
  logic [15:0]         tx_word;
  logic [10:0]         cap_full;
  logic                last_idx, next_frame, rd_ok;

  assign sclk_s    = sclk_sync_reg[1];
  assign sdofs_s   = sdofs_sync_reg[1];
  assign sdo_s     = sdo_sync_reg[1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;

  // Unused byte slots read as zero so idx can always index a full 8-entry table.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
    if (gi < NUM_REGS) begin : g_used
      assign byte_arr[gi] = bytes_reg[8*gi +: 8];
    end else begin : g_unused
      assign byte_arr[gi] = 8'h00;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
    assign idx_onehot[gi] = (idx_reg == 3'(gi));
  end

  assign cur_byte   = byte_arr[idx_reg];
  assign tx_word    = rd_pass_reg ? {2'b11, DEV_ADDR, idx_reg, 8'h00}
                                  : {2'b10, DEV_ADDR, idx_reg, cur_byte};
  assign cap_full   = {cap_reg, sdo_s};
  assign last_idx   = (idx_reg == 3'(NUM_REGS - 1));
  assign next_frame = ~rd_pass_reg & (~last_idx | verify_reg);
  assign rd_ok      = (cap_full[10:8] == idx_reg) && (cap_full[7:0] == cur_byte);
  assign SE         = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= 3'd0;
      bytes_reg      <= '0;
      verify_reg     <= 1'b0;
      rd_pass_reg    <= 1'b0;
      word_reg       <= '0;
      bit_cnt_reg    <= 4'd0;
      gap_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      cap_reg        <= '0;
      cap_cnt_reg    <= 4'd0;
      sclk_sync_reg  <= 2'b00;
      sdofs_sync_reg <= 2'b00;
      sdo_sync_reg   <= 2'b00;
      sclk_prev_reg  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mismatch       <= '0;
      SDIFS          <= 1'b0;
      SDI            <= 1'b0;
    end else begin
      sclk_sync_reg  <= {sclk_sync_reg[0], SCLK};
      sdofs_sync_reg <= {sdofs_sync_reg[0], SDOFS};
      sdo_sync_reg   <= {sdo_sync_reg[0], SDO};
      sclk_prev_reg  <= sclk_s;
      done           <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            bytes_reg   <= cfg_data;
            verify_reg  <= verify;
            rd_pass_reg <= 1'b0;
            idx_reg     <= 3'd0;
            err         <= 1'b0;
            mismatch    <= '0;
            busy        <= 1'b1;
            state_reg   <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (sclk_rise) begin
            SDIFS       <= 1'b1;
            SDI         <= tx_word[15];
            word_reg    <= tx_word[14:0];
            bit_cnt_reg <= 4'd15;
            state_reg   <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (sclk_rise) begin
            SDIFS <= 1'b0;
            if (bit_cnt_reg != 4'd0) begin
              SDI         <= word_reg[14];
              word_reg    <= {word_reg[13:0], 1'b0};
              bit_cnt_reg <= bit_cnt_reg - 4'd1;
            end else begin
              SDI         <= 1'b0;
              gap_cnt_reg <= '0;
              state_reg   <= ST_GAP;
            end
          end
        end

        // The rise that ends a frame is the first idle period; a following frame
        // leaves one rise early because LOAD itself waits for the next rise.
        ST_GAP: begin
          if (next_frame && gap_cnt_reg == GAP_LAST) begin
            if (last_idx) begin
              idx_reg     <= 3'd0;
              rd_pass_reg <= 1'b1;
            end else begin
              idx_reg <= idx_reg + 3'd1;
            end
            state_reg <= ST_LOAD;
          end else if (sclk_rise) begin
            if (!next_frame && gap_cnt_reg == GAP_LAST) begin
              to_cnt_reg <= '0;
              state_reg  <= rd_pass_reg ? ST_RD_WAIT : ST_FINISH;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GW'(1);
            end
          end
        end

        ST_RD_WAIT: begin
          if (sclk_fall && sdofs_s) begin
            cap_reg     <= {9'd0, sdo_s};
            cap_cnt_reg <= 4'd15;
            state_reg   <= ST_RD_CAP;
          end else if (sclk_rise) begin
            if (to_cnt_reg == TO_LAST) begin
              mismatch <= mismatch | idx_onehot;
              err      <= 1'b1;
              if (last_idx) begin
                state_reg <= ST_FINISH;
              end else begin
                idx_reg   <= idx_reg + 3'd1;
                state_reg <= ST_LOAD;
              end
            end else begin
              to_cnt_reg <= to_cnt_reg + TW'(1);
            end
          end
        end

        ST_RD_CAP: begin
          if (sclk_fall) begin
            cap_reg     <= cap_full[9:0];
            cap_cnt_reg <= cap_cnt_reg - 4'd1;
            if (cap_cnt_reg == 4'd1) begin
              if (!rd_ok) begin
                mismatch <= mismatch | idx_onehot;
                err      <= 1'b1;
              end
              if (last_idx) begin
                state_reg <= ST_FINISH;
              end else begin
                idx_reg   <= idx_reg + 3'd1;
                state_reg <= ST_LOAD;
              end
            end
          end
        end

        ST_FINISH: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
